// File: rtl/core_io_axil_bridge.sv
// Purpose : AXI4-Lite master that serves core IN/OUT byte requests against a UART-Lite style peripheral.
//           The bridge polls the status register before every data access.
// Latency : 6 cycles, counting the accept cycle, to RSP_VALID when the slave has zero wait states
//           and the status register is ready on the first poll.
// Backpr. : one request at a time. REQ_READY is high only in IDLE. AXI VALIDs stay high until their READY is seen.
//
// Ports   : CLK/RST_N        clock and asynchronous active-low reset
//           REQ_*            core request (valid/ready; WRITE=1 is OUT/TX, WRITE=0 is IN/RX)
//           RSP_*            one-cycle completion pulse with the received byte and an error flag
//           AR/R/AW/W/B      AXI4-Lite master channels
//
// Options : define IO_TIMEOUT_EN to bound status polling at POLL_LIMIT unsuccessful polls.
//           When the limit is hit, the request completes with RSP_ERR=1 and RSP_RDATA=0.
module core_io_axil_bridge #(
    parameter int                ADDR_W       = 4,
    parameter int                DATA_W       = 32,
    parameter logic [ADDR_W-1:0] RX_OFS       = 'h0,
    parameter logic [ADDR_W-1:0] TX_OFS       = 'h4,
    parameter logic [ADDR_W-1:0] STAT_OFS     = 'h8,
    parameter int                RX_VALID_BIT = 0,
    parameter int                TX_FULL_BIT  = 3,
    parameter int                POLL_LIMIT   = 1023
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                REQ_VALID,
    output logic                REQ_READY,
    input  logic                REQ_WRITE,
    input  logic [7:0]          REQ_WDATA,
    output logic                RSP_VALID,
    output logic [7:0]          RSP_RDATA,
    output logic                RSP_ERR,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic                ARVALID,
    input  logic                ARREADY,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RVALID,
    output logic                RREADY,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] STAT_AR = 3'd1;
    localparam logic [2:0] STAT_R  = 3'd2;
    localparam logic [2:0] DATA_AR = 3'd3;
    localparam logic [2:0] DATA_R  = 3'd4;
    localparam logic [2:0] WR_AW_W = 3'd5;
    localparam logic [2:0] WR_B    = 3'd6;
    localparam logic [2:0] RESP    = 3'd7;

    // Only the lowest byte lane carries data.
    localparam logic [DATA_W/8-1:0] STRB_LO = 1;

    logic [2:0] state;
    logic       wr_q;
    logic [7:0] byte_q;

    // A channel counts as complete once its VALID has dropped, or when it is being accepted this cycle.
    logic aw_ok;
    logic w_ok;

    assign WSTRB = STRB_LO;
    assign aw_ok = !AWVALID || AWREADY;
    assign w_ok  = !WVALID  || WREADY;

`ifdef IO_TIMEOUT_EN
    localparam int              PW        = $clog2(POLL_LIMIT + 1);
    localparam logic [PW-1:0]   POLL_LAST = PW'(POLL_LIMIT - 1);
    logic [PW-1:0] poll_cnt;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            REQ_READY <= 1'b1;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= 8'h00;
            RSP_ERR   <= 1'b0;
            ARADDR    <= '0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            AWADDR    <= '0;
            AWVALID   <= 1'b0;
            WDATA     <= '0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            wr_q      <= 1'b0;
            byte_q    <= 8'h00;
`ifdef IO_TIMEOUT_EN
            poll_cnt  <= '0;
`endif
        end else begin
            RSP_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        wr_q      <= REQ_WRITE;
                        byte_q    <= REQ_WDATA;
                        RSP_ERR   <= 1'b0;
`ifdef IO_TIMEOUT_EN
                        poll_cnt  <= '0;
`endif
                        REQ_READY <= 1'b0;
                        ARADDR    <= STAT_OFS;
                        ARVALID   <= 1'b1;
                        state     <= STAT_AR;
                    end
                end
                STAT_AR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= STAT_R;
                    end
                end
                STAT_R: begin
                    if (RVALID) begin
                        RREADY <= 1'b0;
                        if (RRESP != 2'b00) begin
                            RSP_ERR   <= 1'b1;
                            RSP_VALID <= 1'b1;
                            state     <= RESP;
                        end else if (!wr_q && RDATA[RX_VALID_BIT]) begin
                            ARADDR  <= RX_OFS;
                            ARVALID <= 1'b1;
                            state   <= DATA_AR;
                        end else if (wr_q && !RDATA[TX_FULL_BIT]) begin
                            AWADDR  <= TX_OFS;
                            WDATA   <= DATA_W'(byte_q);
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                            state   <= WR_AW_W;
                        end else begin
`ifdef IO_TIMEOUT_EN
                            poll_cnt <= poll_cnt + 1'b1;
                            // This unsuccessful poll is the POLL_LIMIT-th one, so give up without a data access.
                            if (poll_cnt == POLL_LAST) begin
                                RSP_ERR   <= 1'b1;
                                RSP_RDATA <= 8'h00;
                                RSP_VALID <= 1'b1;
                                state     <= RESP;
                            end else begin
                                ARADDR  <= STAT_OFS;
                                ARVALID <= 1'b1;
                                state   <= STAT_AR;
                            end
`else
                            ARADDR  <= STAT_OFS;
                            ARVALID <= 1'b1;
                            state   <= STAT_AR;
`endif
                        end
                    end
                end
                DATA_AR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= DATA_R;
                    end
                end
                DATA_R: begin
                    if (RVALID) begin
                        RREADY    <= 1'b0;
                        RSP_RDATA <= RDATA[7:0];
                        if (RRESP != 2'b00) begin
                            RSP_ERR <= 1'b1;
                        end
                        RSP_VALID <= 1'b1;
                        state     <= RESP;
                    end
                end
                WR_AW_W: begin
                    // AW and W are retired independently. Each VALID drops only after its own handshake.
                    if (AWVALID && AWREADY) begin
                        AWVALID <= 1'b0;
                    end
                    if (WVALID && WREADY) begin
                        WVALID <= 1'b0;
                    end
                    if (aw_ok && w_ok) begin
                        BREADY <= 1'b1;
                        state  <= WR_B;
                    end
                end
                WR_B: begin
                    if (BVALID) begin
                        BREADY <= 1'b0;
                        if (BRESP != 2'b00) begin
                            RSP_ERR <= 1'b1;
                        end
                        RSP_VALID <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    REQ_READY <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    REQ_READY <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_io_axil_bridge.sv
// Bench for core_io_axil_bridge. A negedge slave model serves the AXI4-Lite channels.
// Expected responses are queued when a request is issued and compared when RSP_VALID appears.
module tb_core_io_axil_bridge;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              REQ_VALID, REQ_READY, REQ_WRITE;
    logic [7:0]        REQ_WDATA;
    logic              RSP_VALID, RSP_ERR;
    logic [7:0]        RSP_RDATA;
    logic [ADDR_W-1:0] ARADDR, AWADDR;
    logic              ARVALID, ARREADY, RVALID, RREADY;
    logic [DATA_W-1:0] RDATA, WDATA;
    logic [1:0]        RRESP, BRESP;
    logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic [3:0]        WSTRB;

    always #5 CLK = ~CLK;

    core_io_axil_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .POLL_LIMIT(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic       err;
        logic [7:0] rdata;
    } rsp_t;
    rsp_t sb_q[$];
    logic [7:0] model_rdata;

    // Slave model knobs and observations.
    logic [31:0] stat_q[$];
    logic [31:0] stat_dflt, rx_dat;
    logic [3:0]  ar_log[$];
    logic [1:0]  st_resp, rx_resp, bresp_v;
    int          aw_dly, w_dly, aw_wait, w_wait;
    logic        ar_en;
    logic        ar_fire, r_fire, aw_fire, w_fire, b_fire, aw_got, w_got, aw_first;
    logic [3:0]  ar_addr;
    int          n_stat, n_rx, n_aw, n_w, n_b;
    logic [3:0]  aw_addr_seen;
    logic [31:0] w_dat_seen;
    logic [3:0]  w_strb_seen;
    int          ncyc = 0, acc_cyc = 0, last_lat = 0, rsp_cnt = 0;

    task automatic slave_clear();
        RVALID = 0; BVALID = 0; AWREADY = 0; WREADY = 0; ARREADY = 1;
        RDATA = '0; RRESP = 0; BRESP = 0;
        ar_fire = 0; r_fire = 0; aw_fire = 0; w_fire = 0; b_fire = 0;
        aw_got = 0; w_got = 0; aw_first = 0; aw_wait = 0; w_wait = 0;
        n_stat = 0; n_rx = 0; n_aw = 0; n_w = 0; n_b = 0;
        ar_log.delete(); stat_q.delete();
        stat_dflt = 0; rx_dat = 0; st_resp = 0; rx_resp = 0; bresp_v = 0;
        aw_dly = 0; w_dly = 0; ar_en = 1;
        aw_addr_seen = 0; w_dat_seen = 0; w_strb_seen = 0;
    endtask

    // Each negedge first completes the handshakes committed at the preceding posedge.
    // It then drives new slave values and records which handshakes will fire at the coming posedge.
    always @(negedge CLK) begin
        ncyc++;
        if (REQ_VALID && REQ_READY) acc_cyc = ncyc;
        if (RSP_VALID) begin
            rsp_cnt++;
            last_lat = ncyc - acc_cyc;
            if (sb_q.size() > 0) begin
                rsp_t e;
                e = sb_q.pop_front();
                chk("rsp_err", RSP_ERR, e.err);
                chk("rsp_rdata", RSP_RDATA, e.rdata);
            end else begin
                chk("rsp_unexpected", 1, 0);
            end
        end
        if (r_fire) RVALID = 0;
        if (b_fire) BVALID = 0;
        if (aw_fire) aw_got = 1;
        if (w_fire) w_got = 1;
        if (ar_fire) begin
            RVALID = 1;
            if (ar_addr == 4'h8) begin
                n_stat++;
                RDATA = (stat_q.size() > 0) ? stat_q.pop_front() : stat_dflt;
                RRESP = st_resp;
            end else begin
                n_rx++;
                RDATA = rx_dat;
                RRESP = rx_resp;
            end
        end
        if (aw_got && w_got) begin
            BVALID = 1; BRESP = bresp_v; aw_got = 0; w_got = 0;
        end
        ARREADY = ar_en;
        AWREADY = AWVALID && (aw_wait >= aw_dly);
        WREADY  = WVALID && (w_wait >= w_dly);
        aw_wait = AWVALID ? aw_wait + 1 : 0;
        w_wait  = WVALID ? w_wait + 1 : 0;
        if (!AWVALID && WVALID) aw_first = 1;
        ar_fire = ARVALID && ARREADY;
        ar_addr = ARADDR;
        if (ar_fire) ar_log.push_back(ARADDR);
        r_fire  = RVALID && RREADY;
        aw_fire = AWVALID && AWREADY;
        if (aw_fire) begin n_aw++; aw_addr_seen = AWADDR; end
        w_fire  = WVALID && WREADY;
        if (w_fire) begin n_w++; w_dat_seen = WDATA; w_strb_seen = WSTRB; end
        b_fire  = BVALID && BREADY;
        if (b_fire) n_b++;
    end

    task automatic wait_ready();
        int n = 0;
        while (!REQ_READY && n < 500) begin
            @(posedge CLK); #1; n++;
        end
        chk("req_ready_wait", REQ_READY, 1);
    endtask

    task automatic do_req(input logic wr, input logic [7:0] b, input logic e_err, input logic [7:0] e_rd);
        int base, n;
        wait_ready();
        REQ_WRITE = wr; REQ_WDATA = b; REQ_VALID = 1;
        sb_q.push_back({e_err, e_rd});
        base = rsp_cnt;
        @(posedge CLK); #1 REQ_VALID = 0;
        n = 0;
        while (rsp_cnt == base && n < 2000) begin
            @(posedge CLK); #1; n++;
        end
        chk("rsp_count", rsp_cnt - base, 1);
        @(posedge CLK); #1;
        model_rdata = e_rd;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        RST_N = 0; REQ_VALID = 0; REQ_WRITE = 0; REQ_WDATA = 0;
        slave_clear();
        model_rdata = 0;
        repeat (3) @(negedge CLK);
        chk("rst_ctrl", {ARVALID, RREADY, AWVALID, WVALID, BREADY, RSP_VALID, REQ_READY}, 7'b0000001);
        chk("rst_addr", {ARADDR, AWADDR}, 0);
        chk("rst_wdata", WDATA, 0);
        chk("rst_rsp", {RSP_ERR, RSP_RDATA}, 0);
        RST_N = 1;
        @(posedge CLK); #1;

        // Read with RX ready on the first poll. The accept cycle counts as the first of 6 cycles.
        slave_clear(); stat_q.push_back(32'h1); rx_dat = 32'hFFFF_FF41;
        do_req(0, 8'h00, 0, 8'h41);
        chk("rd_lat", last_lat, 5);
        chk("rd_ar_cnt", ar_log.size(), 2);
        chk("rd_ar0", ar_log[0], 4'h8);
        chk("rd_ar1", ar_log[1], 4'h0);

        // Write 0x5A with TX not full. RSP_RDATA is expected to keep 0x41.
        slave_clear(); stat_q.push_back(32'h0);
        do_req(1, 8'h5A, 0, model_rdata);
        chk("wr_lat", last_lat, 5);
        chk("wr_awaddr", aw_addr_seen, 4'h4);
        chk("wr_wdata", w_dat_seen, 32'h0000_005A);
        chk("wr_wstrb", w_strb_seen, 4'b0001);
        chk("wr_b_cnt", n_b, 1);

        // TX full on three polls. AWREADY then comes 3 cycles before WREADY.
        slave_clear();
        stat_q.push_back(32'h8); stat_q.push_back(32'h8); stat_q.push_back(32'h8); stat_q.push_back(32'h0);
        w_dly = 3;
        do_req(1, 8'hA7, 0, model_rdata);
        chk("poll_stat_cnt", n_stat, 4);
        chk("poll_aw_w_cnt", {n_aw[15:0], n_w[15:0]}, {16'd1, 16'd1});
        chk("poll_aw_first", aw_first, 1);
        chk("poll_wdata", w_dat_seen, 32'h0000_00A7);

        // Error response on the data read. The byte is still returned.
        slave_clear(); stat_q.push_back(32'h1); rx_dat = 32'h7E; rx_resp = 2'b10;
        do_req(0, 8'h00, 1, 8'h7E);
        chk("rderr_idle", REQ_READY, 1);

        // Error response on the write. RSP_RDATA is expected to keep 0x7E.
        slave_clear(); stat_q.push_back(32'h0); bresp_v = 2'b10;
        do_req(1, 8'h11, 1, model_rdata);
        chk("wrerr_b_cnt", n_b, 1);

`ifdef IO_TIMEOUT_EN
        // RX never ready. With POLL_LIMIT=4 the request ends after four status reads and no data read.
        slave_clear(); stat_dflt = 32'h0;
        do_req(0, 8'h00, 1, 8'h00);
        chk("to_stat_cnt", n_stat, 4);
        chk("to_rx_cnt", n_rx, 0);
`endif

        // Reset while AW/W are stalled. Every VALID must drop asynchronously.
        slave_clear(); stat_q.push_back(32'h0); aw_dly = 1000; w_dly = 1000;
        wait_ready();
        REQ_WRITE = 1; REQ_WDATA = 8'hC3; REQ_VALID = 1;
        @(posedge CLK); #1 REQ_VALID = 0;
        n = 0;
        while (!AWVALID && n < 100) begin
            @(posedge CLK); #1; n++;
        end
        chk("stall_valids", {AWVALID, WVALID}, 2'b11);
        ar_en = 0;
        #2 RST_N = 0;
        #1;
        chk("async_rst_ctrl", {ARVALID, RREADY, AWVALID, WVALID, BREADY, RSP_VALID, REQ_READY}, 7'b0000001);
        chk("async_rst_data", {AWADDR, WDATA[7:0], RSP_RDATA}, 0);
        repeat (2) @(negedge CLK);
        slave_clear();
        RST_N = 1;
        @(posedge CLK); #1;
        chk("post_rst_ready", REQ_READY, 1);
        model_rdata = 0;
        stat_q.push_back(32'h1); rx_dat = 32'h33;
        do_req(0, 8'h00, 0, 8'h33);
        chk("post_rst_rx_cnt", n_rx, 1);
        chk("post_rst_aw_cnt", n_aw, 0);

        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_io_axil_bridge.md
Name: core_io_axil_bridge

Overview:
Parametrised AXI4-Lite master that serves the core's IN/OUT instructions against a UART-Lite style peripheral (RX FIFO, TX FIFO, status register). It accepts one byte request at a time over a valid/ready port. It polls status before each data access, tolerates independent AW/W acceptance, and reports bus errors. The core issues a request from MEMORY and stalls until RSP_VALID.

Parameters:
ADDR_W, 4, AXI address width
DATA_W, 32, AXI data width (>= 8)
RX_OFS, 'h0, RX FIFO register offset
TX_OFS, 'h4, TX FIFO register offset
STAT_OFS, 'h8, status register offset
RX_VALID_BIT, 0, status bit meaning RX FIFO has data
TX_FULL_BIT, 3, status bit meaning TX FIFO full
POLL_LIMIT, 1023, max consecutive unsuccessful status polls (used only with IO_TIMEOUT_EN)

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
REQ_VALID  in  1  core request valid
REQ_READY  out  1  bridge idle, can accept a request
REQ_WRITE  in  1  1 = OUT (TX), 0 = IN (RX)
REQ_WDATA  in  8  byte to transmit
RSP_VALID  out  1  one-cycle completion pulse
RSP_RDATA  out  8  received byte (valid with RSP_VALID on reads)
RSP_ERR  out  1  bus error or timeout (valid with RSP_VALID)
ARADDR  out  ADDR_W  read address
ARVALID  out  1
ARREADY  in  1
RDATA  in  DATA_W
RRESP  in  2
RVALID  in  1
RREADY  out  1
AWADDR  out  ADDR_W  write address
AWVALID  out  1
AWREADY  in  1
WDATA  out  DATA_W  {zeros, byte}
WSTRB  out  DATA_W/8  constant, lowest byte lane only
WVALID  out  1
WREADY  in  1
BRESP  in  2
BVALID  in  1
BREADY  out  1

Behaviour:
- Reset (asynchronous, RST_N low):
  - State is IDLE.
  - All VALID/READY outputs are 0 except REQ_READY, which is 1.
  - ARADDR, AWADDR, WDATA, RSP_RDATA, RSP_ERR and the poll counter are 0.
  - Reset mid-transaction abandons it immediately. The peripheral handshake is not completed.
- States: IDLE, STAT_AR, STAT_R, DATA_AR, DATA_R, WR_AW_W, WR_B, RESP.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID, latch REQ_WRITE/REQ_WDATA, clear RSP_ERR and the poll counter, then go to STAT_AR.
  - REQ_READY is 0 in every other state.
- STAT_AR: ARADDR=STAT_OFS, ARVALID=1. Hold until ARVALID&ARREADY, then ARVALID=0 and go to STAT_R.
- STAT_R: RREADY=1. On RVALID&RREADY, RREADY drops:
  - RRESP != 0: set error, go to RESP.
  - Read request with RDATA[RX_VALID_BIT]=1: go to DATA_AR.
  - Write request with RDATA[TX_FULL_BIT]=0: go to WR_AW_W.
  - Otherwise: increment the poll counter and return to STAT_AR (re-poll).
- DATA_AR: ARADDR=RX_OFS, same AR handshake as STAT_AR, then go to DATA_R.
- DATA_R:
  - On the R handshake, RSP_RDATA <= RDATA[7:0].
  - Error is set if RRESP != 0.
  - Go to RESP.
- WR_AW_W:
  - AWADDR=TX_OFS and WDATA={0, byte}; AWVALID=1 and WVALID=1 on entry.
  - Each VALID drops independently in the cycle after its own READY is seen. Either order is allowed, as is simultaneous acceptance.
  - Go to WR_B once both channels have completed. AWVALID/WVALID never reassert within one transaction.
- WR_B: BREADY=1. On BVALID, error is set if BRESP != 0, BREADY drops, go to RESP.
- RESP: RSP_VALID=1 for exactly one cycle, then return to IDLE. RSP_RDATA/RSP_ERR hold until the next accepted request.
- Write responses leave RSP_RDATA unchanged.
- Latency, zero-wait peripheral, status ready on first poll: 6 cycles from request acceptance to RSP_VALID for reads and writes.
- All outputs are registered. AXI VALIDs are never withdrawn before their READY.

Optional Feature:
IO_TIMEOUT_EN:
- Defined: when the poll counter reaches POLL_LIMIT unsuccessful polls, the bridge goes from STAT_R to RESP with RSP_ERR=1 and RSP_RDATA=0. No data access is issued.
- Undefined: polling is unbounded, the counter is not instantiated, and POLL_LIMIT is ignored.

Test Plan:
- Read, RX status 0x01 on first poll, RX data 0x41, zero-wait slave -> ARADDR sequence 0x8 then 0x0; RSP_VALID once; RSP_RDATA=0x41; RSP_ERR=0; 6 cycles.
- Write 0x5A, status 0x00 -> AWADDR=0x4, WDATA=0x0000005A, WSTRB=0001; single B handshake; RSP_VALID with RSP_ERR=0.
- Write with status 0x08 three times then 0x00; AWREADY 3 cycles before WREADY -> 4 status reads; AWVALID drops first while WVALID holds; exactly one write.
- Read with RRESP=2 on the data read -> RSP_ERR=1; RSP_RDATA=RDATA[7:0]; bridge back in IDLE with REQ_READY=1.
- IO_TIMEOUT_EN with POLL_LIMIT=4, status always 0x00 on a read -> exactly 4 status reads; RSP_ERR=1; RSP_RDATA=0; no read at 0x0.
- RST_N low during WR_AW_W with ARREADY/AWREADY held low -> all VALIDs 0 asynchronously; REQ_READY=1 after release; next request completes normally.
